// File: rtl/axil_cmd_arbiter_pkg.sv
// Shared types and constants for the AXI-Lite command arbiter.
package axil_arb_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Payload latch is sized for the 32b-data / 8b-addr master wrapper.
  localparam int unsigned CMD_ADDR_W = 8;
  localparam int unsigned CMD_DATA_W = 32;

  typedef struct packed {
    logic                  we;
    logic [CMD_ADDR_W-1:0] addr;
    logic [CMD_DATA_W-1:0] wdata;
  } cmd_t;

endpackage

// File: rtl/axil_cmd_arbiter_if.sv
// Requester-side command/response bus and master-side command bus of the arbiter.
interface axil_cmd_arbiter_if #(
  parameter int NREQ   = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
);
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ-1:0]        req_we;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_wdata;
  logic [NREQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]      rsp_rdata;
  logic [1:0]             rsp_resp;
  logic                   rsp_timeout;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_resp, rsp_timeout
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_resp, rsp_timeout
  );
endinterface

interface axil_cmd_arbiter_m_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
);
  logic              m_start;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic              m_done;
  logic [DATA_W-1:0] m_rdata;
  logic [1:0]        m_resp;

  modport master (
    output m_start, m_we, m_addr, m_wdata,
    input  m_done, m_rdata, m_resp
  );

  modport slave (
    input  m_start, m_we, m_addr, m_wdata,
    output m_done, m_rdata, m_resp
  );
endinterface

// File: rtl/axil_cmd_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after the pointer.
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         i_req,
  input  logic [$clog2(NREQ)-1:0] i_ptr,
  output logic [NREQ-1:0]         o_grant,
  output logic [$clog2(NREQ)-1:0] o_idx,
  output logic                    o_any
);
  localparam int PW = $clog2(NREQ);

  logic [PW-1:0] w_cand;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_cand  = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_cand = PW'((32'(i_ptr) + k) % NREQ);
      if (!o_any && i_req[w_cand]) begin
        o_any           = 1'b1;
        o_idx           = w_cand;
        o_grant[w_cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axil_cmd_arbiter.sv
// Round-robin sharing of one AXI-Lite master command port, one transaction
// in flight, with a local watchdog that answers SLVERR if the master stalls.
module axil_cmd_arbiter
  import axil_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  axil_cmd_arbiter_if.slave    req,
  axil_cmd_arbiter_m_if.master m
);
  localparam int PW = $clog2(NREQ);
  localparam int TW = $clog2(TIMEOUT + 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [PW-1:0]     r_ptr;
  logic [PW-1:0]     r_gidx;
  logic [PW-1:0]     w_idx;
  logic [NREQ-1:0]   w_grant;
  logic              w_any;
  cmd_t              r_cmd;
  cmd_t              w_cmd_sel;
  logic [TW-1:0]     r_timer;
  logic              w_expired;
  logic [DATA_W-1:0] r_rdata;
  logic [1:0]        r_resp;
  logic              r_timeout;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .i_req   (req.req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  always_comb begin
    w_cmd_sel       = '0;
    w_cmd_sel.we    = req.req_we[w_idx];
    w_cmd_sel.addr  = CMD_ADDR_W'(req.req_addr[w_idx*ADDR_W +: ADDR_W]);
    w_cmd_sel.wdata = CMD_DATA_W'(req.req_wdata[w_idx*DATA_W +: DATA_W]);
  end

  // Expiry on the TIMEOUT-th WAIT cycle; the timer then reads TIMEOUT and holds.
  assign w_expired = (r_timer >= TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_gidx    <= '0;
      r_cmd     <= '0;
      r_timer   <= '0;
      r_rdata   <= '0;
      r_resp    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_gidx <= w_idx;
            r_cmd  <= w_cmd_sel;
          end
        end
        ISSUE: r_timer <= '0;
        WAIT: begin
          if (r_timer != TW'(TIMEOUT)) begin
            r_timer <= r_timer + 1'b1;
          end
          if (m.m_done) begin
            r_rdata   <= r_cmd.we ? '0 : m.m_rdata;
            r_resp    <= m.m_resp;
            r_timeout <= 1'b0;
          end else if (w_expired) begin
            r_rdata   <= '0;
            r_resp    <= RESP_SLVERR;
            r_timeout <= 1'b1;
          end
        end
        RESP: r_ptr <= (r_gidx == PW'(NREQ - 1)) ? '0 : r_gidx + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    req.req_ready   = '0;
    req.rsp_valid   = '0;
    req.rsp_rdata   = '0;
    req.rsp_resp    = '0;
    req.rsp_timeout = 1'b0;
    m.m_start       = 1'b0;
    m.m_we          = 1'b0;
    m.m_addr        = '0;
    m.m_wdata       = '0;
    unique case (r_state)
      IDLE: begin
        if (!reset) begin
          req.req_ready = w_grant;
        end
        if (w_any) begin
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        m.m_start   = 1'b1;
        m.m_we      = r_cmd.we;
        m.m_addr    = ADDR_W'(r_cmd.addr);
        m.m_wdata   = DATA_W'(r_cmd.wdata);
        w_state_nxt = WAIT;
      end
      WAIT: begin
        m.m_we    = r_cmd.we;
        m.m_addr  = ADDR_W'(r_cmd.addr);
        m.m_wdata = DATA_W'(r_cmd.wdata);
        if (m.m_done || w_expired) begin
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        req.rsp_valid   = NREQ'(1) << r_gidx;
        req.rsp_rdata   = r_rdata;
        req.rsp_resp    = r_resp;
        req.rsp_timeout = r_timeout;
        w_state_nxt     = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axil_cmd_arbiter.sv
// Self-checking bench for axil_cmd_arbiter: directed vector table, reset abort
// sequence, and randomized transactions against a transaction-level model.
module tb_axil_cmd_arbiter;
  localparam int NREQ    = 4;
  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 8;
  localparam int TIMEOUT = 8;

  logic clk;
  logic reset;

  axil_cmd_arbiter_if #(.NREQ(NREQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) rq ();
  axil_cmd_arbiter_m_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) ma ();

  axil_cmd_arbiter #(
    .NREQ(NREQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .req   (rq),
    .m     (ma)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Requester payloads
  logic              p_we    [NREQ];
  logic [ADDR_W-1:0] p_addr  [NREQ];
  logic [DATA_W-1:0] p_wdata [NREQ];

  // Slave behaviour knobs: sl_delay = cycles after start to m_done, 0 = never.
  int         sl_delay;
  logic [1:0] sl_resp;
  logic [DATA_W-1:0] smem [256];

  // Reference model state
  int                m_ptr;
  logic [DATA_W-1:0] mmem [256];

  typedef struct {
    logic [NREQ-1:0]   vld;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    int                dly;
    logic [1:0]        sresp;
    int                g;
    logic [1:0]        resp;
    logic [DATA_W-1:0] rdata;
    logic              to;
    int                lat;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_req(input logic [NREQ-1:0] vld);
    rq.req_valid = vld;
    for (int i = 0; i < NREQ; i++) begin
      rq.req_we[i]                     = p_we[i];
      rq.req_addr[i*ADDR_W +: ADDR_W]  = p_addr[i];
      rq.req_wdata[i*DATA_W +: DATA_W] = p_wdata[i];
    end
  endtask

  // Entered and left at posedge+1 with the DUT idle.
  task automatic run_txn(input logic [NREQ-1:0] vld, input int dly, input logic [1:0] sresp,
                         input int exp_g, input logic [1:0] exp_resp,
                         input logic [DATA_W-1:0] exp_rdata, input logic exp_to, input int exp_lat);
    logic [NREQ-1:0] oh;
    logic [ADDR_W+DATA_W:0] ecmd;
    int lat;
    logic seen;
    logic bad;
    oh   = NREQ'(1) << exp_g;
    ecmd = {p_we[exp_g], p_addr[exp_g], p_wdata[exp_g]};
    sl_delay = dly;
    sl_resp  = sresp;
    drive_req(vld);
    @(negedge clk);
    chk("req_ready", 128'(rq.req_ready), 128'(oh));
    @(posedge clk); #1;
    drive_req('0);
    @(negedge clk);
    chk("m_start", 128'(ma.m_start), 128'(1));
    chk("m_cmd", 128'({ma.m_we, ma.m_addr, ma.m_wdata}), 128'(ecmd));
    lat  = 0;
    seen = 1'b0;
    bad  = 1'b0;
    while (!seen && lat < TIMEOUT + 6) begin
      @(negedge clk);
      lat++;
      if (rq.rsp_valid != '0) begin
        seen = 1'b1;
      end else if (ma.m_start || rq.req_ready != '0 ||
                   {ma.m_we, ma.m_addr, ma.m_wdata} !== ecmd) begin
        bad = 1'b1;
      end
    end
    chk("rsp_valid", 128'(rq.rsp_valid), 128'(oh));
    chk("rsp_latency", 128'(lat), 128'(exp_lat));
    chk("rsp_fields", 128'({rq.rsp_resp, rq.rsp_timeout, rq.rsp_rdata}),
        128'({exp_resp, exp_to, exp_rdata}));
    chk("wait_quiet", 128'(bad), 128'(0));
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive_req('0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Slave: completes sl_delay cycles after m_start, backed by smem.
  initial begin : slave_model
    int cnt;
    logic cur_we;
    logic [ADDR_W-1:0] cur_addr;
    logic [DATA_W-1:0] cur_wdata;
    cnt = 0;
    cur_we = 1'b0;
    cur_addr = '0;
    cur_wdata = '0;
    ma.m_done  = 1'b0;
    ma.m_rdata = '0;
    ma.m_resp  = '0;
    for (int i = 0; i < 256; i++) smem[i] = '0;
    forever begin
      @(negedge clk);
      ma.m_done  = 1'b0;
      ma.m_rdata = '0;
      ma.m_resp  = '0;
      if (reset) begin
        cnt = 0;
        for (int i = 0; i < 256; i++) smem[i] = '0;
      end else if (ma.m_start) begin
        cnt       = sl_delay;
        cur_we    = ma.m_we;
        cur_addr  = ma.m_addr;
        cur_wdata = ma.m_wdata;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          ma.m_done = 1'b1;
          ma.m_resp = sl_resp;
          if (cur_we) begin
            ma.m_rdata = 32'hDEAD_BEEF;
            if (sl_resp == 2'b00) smem[cur_addr] = cur_wdata;
          end else begin
            ma.m_rdata = smem[cur_addr];
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_checks + 1);
    $fatal(1, "time limit");
  end

  initial begin : main
    clk      = 1'b0;
    reset    = 1'b1;
    sl_delay = 0;
    sl_resp  = 2'b00;
    for (int i = 0; i < NREQ; i++) begin
      p_we[i]    = 1'b0;
      p_addr[i]  = '0;
      p_wdata[i] = '0;
    end
    drive_req('0);

    //            vld      we    addr   wdata          dly      sresp  g  resp   rdata          to  lat
    vecs[0]  = '{4'b1111, 1'b1, 8'h10, 32'h1111_1111, 1,       2'b00, 0, 2'b00, 32'h0,         1'b0, 2};
    vecs[1]  = '{4'b1111, 1'b0, 8'h10, 32'h0,         3,       2'b00, 1, 2'b00, 32'h1111_1111, 1'b0, 4};
    vecs[2]  = '{4'b1111, 1'b1, 8'h20, 32'h2222_2222, TIMEOUT, 2'b00, 2, 2'b00, 32'h0,         1'b0, TIMEOUT + 1};
    vecs[3]  = '{4'b1111, 1'b0, 8'h20, 32'h0,         2,       2'b00, 3, 2'b00, 32'h2222_2222, 1'b0, 3};
    vecs[4]  = '{4'b1111, 1'b0, 8'h10, 32'h0,         1,       2'b10, 0, 2'b10, 32'h1111_1111, 1'b0, 2};
    vecs[5]  = '{4'b0001, 1'b1, 8'hf3, 32'hb4b4_b4b4, 1,       2'b00, 0, 2'b00, 32'h0,         1'b0, 2};
    vecs[6]  = '{4'b0010, 1'b1, 8'hf3, 32'hb4b4_b4b4, 1,       2'b00, 1, 2'b00, 32'h0,         1'b0, 2};
    vecs[7]  = '{4'b0010, 1'b0, 8'hf3, 32'h0,         1,       2'b00, 1, 2'b00, 32'hb4b4_b4b4, 1'b0, 2};
    vecs[8]  = '{4'b0100, 1'b1, 8'h30, 32'h3333_3333, 0,       2'b00, 2, 2'b10, 32'h0,         1'b1, TIMEOUT + 1};
    vecs[9]  = '{4'b1000, 1'b0, 8'h20, 32'h0,         TIMEOUT + 1, 2'b00, 3, 2'b10, 32'h0,     1'b1, TIMEOUT + 1};
    vecs[10] = '{4'b1000, 1'b0, 8'h20, 32'h0,         1,       2'b00, 3, 2'b00, 32'h2222_2222, 1'b0, 2};
    vecs[11] = '{4'b0011, 1'b0, 8'h30, 32'h0,         2,       2'b00, 0, 2'b00, 32'h0,         1'b0, 3};
    vecs[12] = '{4'b0101, 1'b1, 8'h40, 32'h4444_4444, 1,       2'b00, 2, 2'b00, 32'h0,         1'b0, 2};

    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("reset_state", 128'({rq.req_ready, rq.rsp_valid, rq.rsp_resp, rq.rsp_timeout, rq.rsp_rdata,
                             ma.m_start, ma.m_we, ma.m_addr, ma.m_wdata}), 128'(0));
    @(posedge clk); #1;
    reset = 1'b0;

    for (int v = 0; v < 13; v++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (i == vecs[v].g) begin
          p_we[i]    = vecs[v].we;
          p_addr[i]  = vecs[v].addr;
          p_wdata[i] = vecs[v].wdata;
        end else begin
          p_we[i]    = ~vecs[v].we;
          p_addr[i]  = vecs[v].addr ^ 8'h5A ^ 8'(i);
          p_wdata[i] = ~vecs[v].wdata ^ 32'(i);
        end
      end
      run_txn(vecs[v].vld, vecs[v].dly, vecs[v].sresp, vecs[v].g, vecs[v].resp,
              vecs[v].rdata, vecs[v].to, vecs[v].lat);
    end

    // Pointer now sits at 3; abort a req3 transaction by reset while in WAIT.
    for (int i = 0; i < NREQ; i++) begin
      p_we[i]    = 1'b1;
      p_addr[i]  = 8'h50;
      p_wdata[i] = 32'h5555_5555 ^ 32'(i);
    end
    sl_delay = 0;
    sl_resp  = 2'b00;
    drive_req(4'b1000);
    @(negedge clk);
    chk("abort_ready", 128'(rq.req_ready), 128'(4'b1000));
    @(posedge clk); #1;
    drive_req('0);
    @(negedge clk);
    chk("abort_start", 128'(ma.m_start), 128'(1));
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    drive_req(4'b0001);
    @(posedge clk); #1;
    @(negedge clk);
    chk("reset_mid_outputs", 128'({rq.req_ready, rq.rsp_valid, rq.rsp_resp, rq.rsp_timeout, rq.rsp_rdata,
                                   ma.m_start, ma.m_we, ma.m_addr, ma.m_wdata}), 128'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    drive_req('0);
    @(negedge clk);
    chk("post_reset_no_rsp", 128'(rq.rsp_valid), 128'(0));
    @(posedge clk); #1;
    p_we[0] = 1'b1; p_addr[0] = 8'h60; p_wdata[0] = 32'h6060_6060;
    p_we[3] = 1'b1; p_addr[3] = 8'h63; p_wdata[3] = 32'h6363_6363;
    run_txn(4'b1001, 1, 2'b00, 0, 2'b00, 32'h0, 1'b0, 2);

    // Randomized transactions against the transaction-level model.
    do_reset();
    m_ptr = 0;
    for (int i = 0; i < 256; i++) mmem[i] = '0;
    for (int t = 0; t < 24; t++) begin
      logic [NREQ-1:0]   vld;
      int                dly;
      int                g;
      int                idx;
      int                lat;
      logic [1:0]        sr;
      logic [1:0]        eresp;
      logic [DATA_W-1:0] erd;
      logic              eto;
      vld = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      for (int i = 0; i < NREQ; i++) begin
        p_we[i]    = 1'($urandom_range(0, 1));
        p_addr[i]  = 8'($urandom_range(0, 3) * 16);
        p_wdata[i] = $urandom;
      end
      case ($urandom_range(0, 5))
        0:       dly = 0;
        1:       dly = TIMEOUT;
        default: dly = $urandom_range(1, 3);
      endcase
      sr = ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b00;
      g = -1;
      for (int k = 0; k < NREQ; k++) begin
        idx = (m_ptr + k) % NREQ;
        if (g < 0 && vld[idx]) g = idx;
      end
      if (dly == 0) begin
        eto = 1'b1; eresp = 2'b10; erd = '0; lat = TIMEOUT + 1;
      end else begin
        eto   = 1'b0;
        eresp = sr;
        lat   = dly + 1;
        erd   = p_we[g] ? '0 : mmem[p_addr[g]];
        if (p_we[g] && sr == 2'b00) mmem[p_addr[g]] = p_wdata[g];
      end
      m_ptr = (g + 1) % NREQ;
      run_txn(vld, dly, sr, g, eresp, erd, eto, lat);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
